dfcontrol_rr: RTL and testbench
===============================

# dfcontrol_rr

Parametrised N-channel data-flow controller, successor to the two-channel data-flow control stage of the PCIe switching datapath. It sits between the ingress push sources and a bank of NCH FIFOs. It gates per-channel writes against full, almost-full and pause status, and drains the FIFOs through a single round-robin read port with downstream backpressure. It also provides sticky per-channel error capture with clear and a saturating count of refused pushes.

## Interface
Parameters:
- NCH, 4, number of channels/FIFOs (2..16)
- SELW, $clog2(NCH) (min 1), width of read_sel
- DCW, 8, width of drop counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- push  in  NCH  per-channel write request from upstream
- fifo_full  in  NCH  FIFO full status
- almost_full  in  NCH  FIFO has exactly one free slot
- fifo_empty  in  NCH  FIFO empty status
- almost_empty  in  NCH  FIFO holds exactly one entry
- fifo_pause  in  NCH  per-channel write pause from next stage
- fifo_error  in  NCH  FIFO error pulse/level
- out_ready  in  1  downstream can accept one read this cycle
- error_clr  in  1  clears sticky error state
- write  out  NCH  registered per-channel FIFO write enable
- read  out  NCH  registered one-hot FIFO read enable
- read_valid  out  1  registered, equals |read
- read_sel  out  SELW  registered index of granted channel (holds last grant when read_valid=0)
- error_vec  out  NCH  sticky per-channel error flags
- Error  out  1  registered OR of error_vec
- drop_cnt  out  DCW  saturating count of refused pushes

## Operation
- Reset (reset=0, async): write=0, read=0, read_valid=0, read_sel=0, error_vec=0, Error=0, drop_cnt=0, round-robin pointer last=NCH-1 (first search starts at channel 0).
- Write gating, per channel i, evaluated each cycle:
  - wr_ok[i] = ~fifo_full[i] & ~fifo_pause[i] & ~(almost_full[i] & write[i]).
  - A write issued in the previous cycle consumes the last slot advertised by almost_full.
  - write[i] <= push[i] & wr_ok[i].
- Drop counting:
  - Refused pushes this cycle = popcount(push & ~wr_ok), range 0..NCH.
  - drop_cnt <= min(drop_cnt + refused, 2^DCW-1).
  - The sum is computed at DCW+SELW+1 bits before saturation; the counter never wraps.
- Read arbitration:
  - elig[i] = ~fifo_empty[i] & ~(almost_empty[i] & read[i]). A read in flight consumes the single entry.
  - If out_ready=0 or elig=0: read<=0, read_valid<=0, read_sel holds, pointer holds.
  - Otherwise grant the first eligible channel searching last+1, last+2, … modulo NCH, wrapping from NCH-1 to 0.
  - On a grant: read<=onehot(g), read_sel<=g, read_valid<=1, last<=g.
  - Only one channel is read per cycle.
- Errors:
  - error_vec[i] <= (error_vec[i] & ~error_clr) | fifo_error[i]. Set wins over a simultaneous clear.
  - Error <= |(next error_vec).
- Write and read paths are independent: a channel may be written and read in the same cycle.

## Timing
- All outputs are registered, with 1-cycle latency from sampled inputs; there is no combinational input-to-output path.
- out_ready is sampled at edge k; the resulting read is visible after edge k and is consumed by the FIFO at edge k+1.
- Back-to-back reads of the same channel are allowed when it is neither empty nor almost_empty. A channel with almost_empty=1 is granted at most every other cycle.
- Error rises one cycle after fifo_error. Error falls one cycle after error_clr, provided no new error is present.
- Reset assertion mid-operation clears outputs without waiting for clk. On deassertion, the first grant goes to the lowest eligible channel.

## Test plan
- Reset check: hold reset=0 with random inputs → all outputs 0. Release reset; NCH=4, all channels non-empty, out_ready=1 → read_sel sequence 0,1,2,3,0, read_valid=1 every cycle.
- Write gating: push=4'b1111, fifo_full=0001, fifo_pause=0010, almost_full=0100 with write[2]=1 in the prior cycle → write=1000. drop_cnt increases by 3 per cycle.
- Drop saturation: DCW=8, push=1111, fifo_full=1111 for 70 cycles → drop_cnt reaches 255 and holds (no wrap at 256).
- Backpressure and skip: only channels 1 and 3 eligible, out_ready toggling 1,0,1,1 → grants 1, none (read_sel holds 1), 3, 1.
- Almost-empty: channel 2 alone with almost_empty=1, fifo_empty=0 → read alternates 0100, 0000, 0100.
- Sticky error: pulse fifo_error[1] for 1 cycle → error_vec=0010 and Error=1 held. Assert error_clr and fifo_error[3] on the same cycle → error_vec=1000, Error stays 1.

Source files
------------

// File: rtl/dfcontrol_rr.sv
// dfcontrol_rr: N-channel FIFO write gating, round-robin read arbitration, sticky errors, drop counter
// Ports:
//   clk_i            clock, all state updates on rising edge
//   rst_ni           asynchronous active-low reset
//   push_i           per-channel write requests from upstream
//   fifo_full_i      FIFO full status
//   almost_full_i    FIFO has exactly one free slot
//   fifo_empty_i     FIFO empty status
//   almost_empty_i   FIFO holds exactly one entry
//   fifo_pause_i     per-channel write pause from next stage
//   fifo_error_i     FIFO error pulse/level
//   out_ready_i      downstream accepts one read this cycle
//   error_clr_i      clears sticky error flags
//   write_o          registered per-channel write enables
//   read_o           registered one-hot read enable
//   read_valid_o     registered OR of read_o
//   read_sel_o       index of last granted channel
//   error_vec_o      sticky per-channel error flags
//   error_o          registered OR of error_vec_o
//   drop_cnt_o       saturating count of refused pushes
module dfcontrol_rr #(
    parameter int NCH  = 4,
    parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int DCW  = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NCH-1:0]  push_i,
    input  logic [NCH-1:0]  fifo_full_i,
    input  logic [NCH-1:0]  almost_full_i,
    input  logic [NCH-1:0]  fifo_empty_i,
    input  logic [NCH-1:0]  almost_empty_i,
    input  logic [NCH-1:0]  fifo_pause_i,
    input  logic [NCH-1:0]  fifo_error_i,
    input  logic            out_ready_i,
    input  logic            error_clr_i,
    output logic [NCH-1:0]  write_o,
    output logic [NCH-1:0]  read_o,
    output logic            read_valid_o,
    output logic [SELW-1:0] read_sel_o,
    output logic [NCH-1:0]  error_vec_o,
    output logic            error_o,
    output logic [DCW-1:0]  drop_cnt_o
);
    localparam int SW = DCW + SELW + 1;
    logic [NCH-1:0]  write_q, write_d, read_q, read_d, error_vec_q, error_vec_d, wr_ok, elig;
    logic            read_valid_q, read_valid_d, error_q, error_d, gnt;
    logic [SELW-1:0] read_sel_q, read_sel_d, last_q, last_d, gnt_idx, idx;
    logic [DCW-1:0]  drop_q, drop_d;
    logic [SELW:0]   refused;
    logic [SW-1:0]   drop_sum;

    always_comb begin
        // A write or read issued last cycle already consumed the single slot/entry
        // that almost_full/almost_empty advertises.
        wr_ok = ~fifo_full_i & ~fifo_pause_i & ~(almost_full_i & write_q);
        elig = ~fifo_empty_i & ~(almost_empty_i & read_q);
        write_d = push_i & wr_ok;
        refused = '0;
        for (int i = 0; i < NCH; i++) refused = refused + (SELW+1)'(push_i[i] & ~wr_ok[i]);
        // Wide sum so saturation is detected before any wrap.
        drop_sum = SW'(drop_q) + SW'(refused);
        drop_d = (drop_sum > SW'({DCW{1'b1}})) ? '1 : drop_sum[DCW-1:0];
        gnt = 1'b0;
        gnt_idx = '0;
        idx = '0;
        // Search starts just after the previous grant and wraps modulo NCH.
        for (int k = 1; k <= NCH; k++) begin
            idx = SELW'((int'(last_q) + k) % NCH);
            if (!gnt && elig[idx]) begin
                gnt = 1'b1;
                gnt_idx = idx;
            end
        end
        read_valid_d = out_ready_i & gnt;
        read_d = read_valid_d ? (NCH'(1) << gnt_idx) : '0;
        read_sel_d = read_valid_d ? gnt_idx : read_sel_q;
        last_d = read_valid_d ? gnt_idx : last_q;
        error_vec_d = (error_vec_q & ~{NCH{error_clr_i}}) | fifo_error_i;
        error_d = |error_vec_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q <= '0;
            read_q <= '0;
            read_valid_q <= 1'b0;
            read_sel_q <= '0;
            last_q <= SELW'(NCH - 1);
            error_vec_q <= '0;
            error_q <= 1'b0;
            drop_q <= '0;
        end else begin
            write_q <= write_d;
            read_q <= read_d;
            read_valid_q <= read_valid_d;
            read_sel_q <= read_sel_d;
            last_q <= last_d;
            error_vec_q <= error_vec_d;
            error_q <= error_d;
            drop_q <= drop_d;
        end
    end

    assign write_o = write_q;
    assign read_o = read_q;
    assign read_valid_o = read_valid_q;
    assign read_sel_o = read_sel_q;
    assign error_vec_o = error_vec_q;
    assign error_o = error_q;
    assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_dfcontrol_rr.sv
// tb_dfcontrol_rr: directed scoreboard bench for dfcontrol_rr with NCH=4, DCW=8
module tb_dfcontrol_rr;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] push = '0, full = '0, af = '0, empty = '1, ae = '0, pause = '0, ferr = '0;
    logic       out_ready = 1'b0, clr = 1'b0;
    logic [3:0] write, read, error_vec;
    logic       read_valid, error;
    logic [1:0] read_sel;
    logic [7:0] drop_cnt;
    int         vectors = 0;
    int         miss = 0;

    typedef struct {
        logic [3:0] wr;
        logic [3:0] rd;
        logic       rv;
        logic [1:0] sel;
        logic [3:0] ev;
        logic       er;
        logic [7:0] dc;
    } exp_t;

    exp_t sb[$];

    dfcontrol_rr #(.NCH(4), .DCW(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .fifo_full_i(full),
        .almost_full_i(af), .fifo_empty_i(empty), .almost_empty_i(ae),
        .fifo_pause_i(pause), .fifo_error_i(ferr), .out_ready_i(out_ready),
        .error_clr_i(clr), .write_o(write), .read_o(read), .read_valid_o(read_valid),
        .read_sel_o(read_sel), .error_vec_o(error_vec), .error_o(error), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [3:0] wr, logic [3:0] rd, logic rv, logic [1:0] sel,
                                logic [3:0] ev, logic er, logic [7:0] dc);
        exp_t e;
        e.wr = wr; e.rd = rd; e.rv = rv; e.sel = sel; e.ev = ev; e.er = er; e.dc = dc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic compare();
        exp_t x;
        x = sb.pop_front();
        chk("write", 32'(write), 32'(x.wr));
        chk("read", 32'(read), 32'(x.rd));
        chk("read_valid", 32'(read_valid), 32'(x.rv));
        chk("read_sel", 32'(read_sel), 32'(x.sel));
        chk("error_vec", 32'(error_vec), 32'(x.ev));
        chk("error", 32'(error), 32'(x.er));
        chk("drop_cnt", 32'(drop_cnt), 32'(x.dc));
    endtask

    task automatic tick(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            {push, full, af, empty} = 16'($urandom);
            {ae, pause, ferr} = 12'($urandom);
            {out_ready, clr} = 2'($urandom);
            tick(mk(4'h0, 4'h0, 0, 2'd0, 4'h0, 0, 8'd0));
        end
        rst_n = 1'b1;
        {push, full, af, pause, ferr, ae} = '0;
        clr = 1'b0;
        empty = 4'b0000;
        out_ready = 1'b1;
        tick(mk(4'h0, 4'b0001, 1, 2'd0, 4'h0, 0, 8'd0));
        tick(mk(4'h0, 4'b0010, 1, 2'd1, 4'h0, 0, 8'd0));
        tick(mk(4'h0, 4'b0100, 1, 2'd2, 4'h0, 0, 8'd0));
        tick(mk(4'h0, 4'b1000, 1, 2'd3, 4'h0, 0, 8'd0));
        tick(mk(4'h0, 4'b0001, 1, 2'd0, 4'h0, 0, 8'd0));
        out_ready = 1'b0;
        push = 4'b0100;
        tick(mk(4'b0100, 4'h0, 0, 2'd0, 4'h0, 0, 8'd0));
        push = 4'b1111; full = 4'b0001; pause = 4'b0010; af = 4'b0100;
        tick(mk(4'b1000, 4'h0, 0, 2'd0, 4'h0, 0, 8'd3));
        tick(mk(4'b1100, 4'h0, 0, 2'd0, 4'h0, 0, 8'd5));
        tick(mk(4'b1000, 4'h0, 0, 2'd0, 4'h0, 0, 8'd8));
        full = 4'b1111; pause = '0; af = '0;
        for (int k = 1; k <= 70; k++)
            tick(mk(4'h0, 4'h0, 0, 2'd0, 4'h0, 0, (8 + 4 * k > 255) ? 8'd255 : 8'(8 + 4 * k)));
        push = '0; full = '0;
        tick(mk(4'h0, 4'h0, 0, 2'd0, 4'h0, 0, 8'd255));
        empty = 4'b0101;
        out_ready = 1'b1;
        tick(mk(4'h0, 4'b0010, 1, 2'd1, 4'h0, 0, 8'd255));
        out_ready = 1'b0;
        tick(mk(4'h0, 4'b0000, 0, 2'd1, 4'h0, 0, 8'd255));
        out_ready = 1'b1;
        tick(mk(4'h0, 4'b1000, 1, 2'd3, 4'h0, 0, 8'd255));
        tick(mk(4'h0, 4'b0010, 1, 2'd1, 4'h0, 0, 8'd255));
        empty = 4'b1011; ae = 4'b0100;
        tick(mk(4'h0, 4'b0100, 1, 2'd2, 4'h0, 0, 8'd255));
        tick(mk(4'h0, 4'b0000, 0, 2'd2, 4'h0, 0, 8'd255));
        tick(mk(4'h0, 4'b0100, 1, 2'd2, 4'h0, 0, 8'd255));
        out_ready = 1'b0; empty = 4'b1111; ae = '0;
        ferr = 4'b0010;
        tick(mk(4'h0, 4'h0, 0, 2'd2, 4'b0010, 1, 8'd255));
        ferr = '0;
        tick(mk(4'h0, 4'h0, 0, 2'd2, 4'b0010, 1, 8'd255));
        clr = 1'b1; ferr = 4'b1000;
        tick(mk(4'h0, 4'h0, 0, 2'd2, 4'b1000, 1, 8'd255));
        tick(mk(4'h0, 4'h0, 0, 2'd2, 4'b1000, 1, 8'd255));
        ferr = '0;
        tick(mk(4'h0, 4'h0, 0, 2'd2, 4'b0000, 0, 8'd255));
        clr = 1'b0;
        tick(mk(4'h0, 4'h0, 0, 2'd2, 4'b0000, 0, 8'd255));
        out_ready = 1'b1; empty = 4'b0000; push = 4'b1111;
        tick(mk(4'b1111, 4'b1000, 1, 2'd3, 4'h0, 0, 8'd255));
        #3 rst_n = 1'b0;
        #1 sb.push_back(mk(4'h0, 4'h0, 0, 2'd0, 4'h0, 0, 8'd0));
        compare();
        rst_n = 1'b1;
        push = '0;
        tick(mk(4'h0, 4'b0001, 1, 2'd0, 4'h0, 0, 8'd0));
        tick(mk(4'h0, 4'b0010, 1, 2'd1, 4'h0, 0, 8'd0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
